square_bounce_painter: RTL and testbench
========================================

Name: square_bounce_painter

Overview:
- Pixel-domain painter between the display timing generator and the VGA output pins. Consumes the timing generator's sx/sy/de/hsync/vsync.
- Draws a parametrised square of configurable size and colour on a background, with an optional one-pixel screen border.
- The square moves diagonally at a fixed speed and bounces off the screen edges.
- Position updates once per frame, during vertical blanking, so frames never tear.

Parameters:
- CORDW, 10, screen coordinate width in bits.
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- SQ_SIZE, 200, square side in pixels; must be < H_RES and < V_RES.
- SPEED, 4, pixels moved per frame on each axis; 1..SQ_SIZE.
- FG_RGB, 12'hFFF, square and border colour (R[11:8] G[7:4] B[3:0]).
- BG_RGB, 12'h137, background colour.

Ports:
- clk_pix, in, 1, pixel clock.
- rst_pix, in, 1, synchronous active-high reset.
- sx, in, CORDW, current horizontal coordinate.
- sy, in, CORDW, current vertical coordinate.
- de, in, 1, data enable (active area).
- hsync, in, 1, horizontal sync from timing generator.
- vsync, in, 1, vertical sync from timing generator.
- mode, in, 2, 00 static, 01 bounce, 10 recentre, 11 reserved (treated as static).
- border_en, in, 1, draw the 1-pixel border at the screen edges.
- vga_hsync, out, 1, registered hsync.
- vga_vsync, out, 1, registered vsync.
- vga_r, out, 4, registered red.
- vga_g, out, 4, registered green.
- vga_b, out, 4, registered blue.
- edge_hit, out, 1, one-cycle pulse when a bounce occurs.

Behaviour:
- **Reset (synchronous, rst_pix=1 at clk_pix edge):**
  - qx=(H_RES-SQ_SIZE)/2, qy=(V_RES-SQ_SIZE)/2 (220/140 at defaults).
  - dir_x=right, dir_y=down.
  - vga_r/g/b=0, vga_hsync=1, vga_vsync=1, edge_hit=0.
  - Reset mid-frame abandons the current position immediately.
- **Frame tick:** tick=1 in the cycle where sx==0 && sy==V_RES (first blanking line). All position and direction updates happen only on tick; mode is sampled only on tick.
- **Max positions:** XMAX=H_RES-SQ_SIZE (440), YMAX=V_RES-SQ_SIZE (280). Comparisons use CORDW+1 bits, so there is no wrap.
- **Bounce mode, X axis (Y is identical with YMAX):**
  - Moving right: if qx+SPEED >= XMAX, then qx<=XMAX, dir_x<=left, and the axis reports a hit. Otherwise qx<=qx+SPEED.
  - Moving left: if qx <= SPEED, then qx<=0, dir_x<=right, and the axis reports a hit. Otherwise qx<=qx-SPEED.
- **edge_hit:** asserted for exactly the one cycle after the tick if either axis hit, including a simultaneous corner hit (a single pulse). Otherwise 0.
- **Static / reserved mode:** qx, qy and the directions hold.
- **Recentre mode:** qx and qy load their reset values; directions are left unchanged.
- **Pixel classification (combinational on the inputs):**
  - square = sx>=qx && sx<qx+SQ_SIZE && sy>=qy && sy<qy+SQ_SIZE. This is inclusive-exclusive, giving exactly SQ_SIZE pixels per side.
  - border = border_en && (sx==0 || sy==0 || sx==H_RES-1 || sy==V_RES-1).
  - colour = FG_RGB if square||border, else BG_RGB. Forced to 0 when de=0.
- **Output stage:** one register stage. vga_* at cycle n+1 reflect the inputs at cycle n. hsync and vsync are delayed identically to colour, so alignment is preserved.
- **Position timing:** qx/qy change only in blanking, so every visible frame uses one consistent position.

Test Plan:
- Reset for 2 cycles, then sx=220, sy=140, de=1 → next cycle RGB=F,F,F. sx=219 → 1,3,7. sx=420 → 1,3,7. de=0 → 0,0,0. vga_hsync/vga_vsync track inputs with 1-cycle delay.
- mode=01, drive one tick → qx=224, qy=144, edge_hit=0. Pixel (224,144) → FG; (223,144) → BG.
- mode=01, 35 ticks → qy=280 with dir_y flipped and edge_hit pulses once (qx=360). Tick 36 → qy=276, qx=364. Tick 55 → qx=440, second edge_hit pulse. Tick 56 → qx=436.
- Corner case with SQ_SIZE=200, SPEED=20, start centre: ticks 7 and 11 produce Y and X hits respectively. Force qx/qy to a simultaneous corner (e.g. H_RES=V_RES=480) → single edge_hit pulse, both directions flip.
- mode=00 over 10 ticks → qx/qy unchanged. Switch to mode=10 after motion → next tick restores 220/140, and dir is unchanged on the following bounce tick.
- border_en=1: pixels (0,100), (639,100), (100,479) → FG. border_en=0 → BG. Assert rst_pix mid-line → next cycle outputs 0/0/0 with syncs=1, and qx=220 on release.

Source files
------------

// File: rtl/square_bounce_painter.sv
// Paints a bouncing square (plus optional 1-pixel screen border) over a flat background.
// Position/direction update once per frame on the first vertical-blanking line.
module square_bounce_painter #(
    parameter int          CORDW   = 10,
    parameter int          H_RES   = 640,
    parameter int          V_RES   = 480,
    parameter int          SQ_SIZE = 200,
    parameter int          SPEED   = 4,
    parameter logic [11:0] FG_RGB  = 12'hFFF,
    parameter logic [11:0] BG_RGB  = 12'h137
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [1:0]       mode,
    input  logic             border_en,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             edge_hit
);
    // One extra bit so qx+SPEED and qx+SQ_SIZE never wrap.
    localparam int               CW    = CORDW + 1;
    localparam logic [CW-1:0]    XMAX  = CW'(H_RES - SQ_SIZE);
    localparam logic [CW-1:0]    YMAX  = CW'(V_RES - SQ_SIZE);
    localparam logic [CW-1:0]    SPD   = CW'(SPEED);
    localparam logic [CW-1:0]    SQ    = CW'(SQ_SIZE);
    localparam logic [CW-1:0]    HLAST = CW'(H_RES - 1);
    localparam logic [CW-1:0]    VLAST = CW'(V_RES - 1);
    localparam logic [CW-1:0]    VTICK = CW'(V_RES);
    localparam logic [CORDW-1:0] X0    = CORDW'((H_RES - SQ_SIZE) / 2);
    localparam logic [CORDW-1:0] Y0    = CORDW'((V_RES - SQ_SIZE) / 2);

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_BOUNCE   = 2'b01,
        MODE_RECENTRE = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef struct packed {
        logic [CORDW-1:0] pos;
        logic             fwd;
        logic             hit;
    } axis_t;

    function automatic axis_t step_axis(input logic [CORDW-1:0] pos,
                                        input logic             fwd,
                                        input logic [CW-1:0]    maxp);
        axis_t         r;
        logic [CW-1:0] p;
        logic [CW-1:0] s;
        p     = {1'b0, pos};
        r.pos = pos;
        r.fwd = fwd;
        r.hit = 1'b0;
        if (fwd) begin
            s = p + SPD;
            if (s >= maxp) begin
                r.pos = maxp[CORDW-1:0];
                r.fwd = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = s[CORDW-1:0];
            end
        end else begin
            s = p - SPD;
            if (p <= SPD) begin
                r.pos = '0;
                r.fwd = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = s[CORDW-1:0];
            end
        end
        return r;
    endfunction

    logic [CORDW-1:0] qx_q, qx_d, qy_q, qy_d;
    logic             dx_q, dx_d, dy_q, dy_d;
    logic             hit_q, hit_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, vs_q;

    logic [CW-1:0] sxw, syw, qxw, qyw;
    logic          tick, in_sq, on_border;
    axis_t         ax, ay;

    assign sxw  = {1'b0, sx};
    assign syw  = {1'b0, sy};
    assign qxw  = {1'b0, qx_q};
    assign qyw  = {1'b0, qy_q};
    assign tick = (sx == '0) && (syw == VTICK);
    assign ax   = step_axis(qx_q, dx_q, XMAX);
    assign ay   = step_axis(qy_q, dy_q, YMAX);

    always_comb begin
        qx_d  = qx_q;
        qy_d  = qy_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        hit_d = 1'b0;
        if (tick) begin
            case (mode_e'(mode))
                MODE_BOUNCE: begin
                    qx_d  = ax.pos;
                    dx_d  = ax.fwd;
                    qy_d  = ay.pos;
                    dy_d  = ay.fwd;
                    hit_d = ax.hit | ay.hit;
                end
                MODE_RECENTRE: begin
                    qx_d = X0;
                    qy_d = Y0;
                end
                default: ;
            endcase
        end
    end

    // Inclusive-exclusive bounds give exactly SQ_SIZE pixels per side.
    assign in_sq = (sxw >= qxw) && (sxw < qxw + SQ) && (syw >= qyw) && (syw < qyw + SQ);
    assign on_border = border_en &&
                       ((sx == '0) || (sy == '0) || (sxw == HLAST) || (syw == VLAST));

    always_comb begin
        rgb_d = '0;
        if (de) rgb_d = (in_sq || on_border) ? FG_RGB : BG_RGB;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            qx_q  <= X0;
            qy_q  <= Y0;
            dx_q  <= 1'b1;
            dy_q  <= 1'b1;
            hit_q <= 1'b0;
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            qx_q  <= qx_d;
            qy_q  <= qy_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            hit_q <= hit_d;
            rgb_q <= rgb_d;
            hs_q  <= hsync;
            vs_q  <= vsync;
        end
    end

    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;
    assign edge_hit  = hit_q;
endmodule

// File: tb/tb_square_bounce_painter.sv
// Randomised and directed bench for square_bounce_painter against a frame-level
// model of the square position and direction.
module tb_square_bounce_painter;
    localparam int H = 640, V = 480, SQ = 200, SP = 4;
    localparam int XM = H - SQ, YM = V - SQ;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync, border_en;
    logic [1:0] mode;
    logic       vga_hsync, vga_vsync, edge_hit;
    logic [3:0] vga_r, vga_g, vga_b;

    int checks = 0;
    int errors = 0;

    // model state: position and direction (1 = right/down)
    int mx, my;
    bit mdx, mdy;

    square_bounce_painter dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
        .hsync(hsync), .vsync(vsync), .mode(mode), .border_en(border_en),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .edge_hit(edge_hit)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic logic [11:0] rgb_now();
        return {vga_r, vga_g, vga_b};
    endfunction

    function automatic logic [11:0] exp_rgb(int x, int y, bit d, bit b);
        bit sq, bd;
        if (!d) return 12'h000;
        sq = (x >= mx) && (x < mx + SQ) && (y >= my) && (y < my + SQ);
        bd = b && (x == 0 || y == 0 || x == H - 1 || y == V - 1);
        return (sq || bd) ? 12'hFFF : 12'h137;
    endfunction

    function automatic void model_reset();
        mx = XM / 2; my = YM / 2; mdx = 1; mdy = 1;
    endfunction

    // One frame of motion; returns whether any wall was hit.
    function automatic bit model_tick(int m);
        int nx, ny;
        bit hit = 0;
        if (m == 2) begin
            mx = XM / 2; my = YM / 2;
        end else if (m == 1) begin
            nx = mx + (mdx ? SP : -SP);
            ny = my + (mdy ? SP : -SP);
            if (nx >= XM) begin mx = XM; mdx = 0; hit = 1; end
            else if (nx <= 0) begin mx = 0; mdx = 1; hit = 1; end
            else mx = nx;
            if (ny >= YM) begin my = YM; mdy = 0; hit = 1; end
            else if (ny <= 0) begin my = 0; mdy = 1; hit = 1; end
            else my = ny;
        end
        return hit;
    endfunction

    task automatic probe(input int x, input int y, input bit d, input bit b,
                         output logic [11:0] rgb);
        sx = 10'(x); sy = 10'(y); de = d; border_en = b;
        step();
        rgb = rgb_now();
    endtask

    // Drives the frame tick cycle; edge_hit is visible right after this edge.
    task automatic tick(input logic [1:0] m, output bit exp_hit);
        sx = '0; sy = 10'(V); de = 0; mode = m;
        exp_hit = model_tick(int'(m));
        step();
    endtask

    task automatic test_reset();
        rst_pix = 1; sx = 10'd220; sy = 10'd140; de = 1; hsync = 0; vsync = 0;
        mode = 2'b01; border_en = 1;
        step(); step();
        checks++;
        if ({rgb_now(), vga_hsync, vga_vsync, edge_hit} !== {12'h000, 3'b110}) begin
            errors++;
            $display("FAIL reset: rgb=%h hs=%b vs=%b hit=%b want 000 1 1 0",
                     rgb_now(), vga_hsync, vga_vsync, edge_hit);
        end
        rst_pix = 0; hsync = 1; vsync = 1; border_en = 0;
        model_reset();
    endtask

    task automatic test_pixels();
        logic [11:0] r;
        int xs[5] = '{220, 219, 420, 419, 300};
        bit ds[5] = '{1, 1, 1, 1, 0};
        logic [11:0] want[5] = '{12'hFFF, 12'h137, 12'h137, 12'hFFF, 12'h000};
        for (int i = 0; i < 5; i++) begin
            probe(xs[i], 140, ds[i], 0, r);
            checks++;
            if (r !== want[i]) begin
                errors++;
                $display("FAIL pixel(%0d,140,de=%0d): got %h want %h", xs[i], ds[i], r, want[i]);
            end
        end
    endtask

    task automatic test_sync_delay();
        logic [1:0] pat[4] = '{2'b01, 2'b10, 2'b00, 2'b11};
        logic [1:0] prev = {hsync, vsync};
        for (int i = 0; i < 4; i++) begin
            {hsync, vsync} = pat[i];
            #1;
            checks++;
            if ({vga_hsync, vga_vsync} !== prev) begin
                errors++;
                $display("FAIL sync_hold: got %b want %b", {vga_hsync, vga_vsync}, prev);
            end
            step();
            checks++;
            if ({vga_hsync, vga_vsync} !== pat[i]) begin
                errors++;
                $display("FAIL sync_delay: got %b want %b", {vga_hsync, vga_vsync}, pat[i]);
            end
            prev = pat[i];
        end
        hsync = 1; vsync = 1;
    endtask

    task automatic test_bounce();
        logic [11:0] r;
        bit eh;
        int pulses = 0;
        for (int t = 1; t <= 56; t++) begin
            tick(2'b01, eh);
            checks++;
            if (edge_hit !== eh) begin
                errors++;
                $display("FAIL bounce_hit tick %0d: got %b want %b", t, edge_hit, eh);
            end
            if (edge_hit === 1'b1) pulses++;
            probe(mx, my, 1, 0, r);
            checks++;
            if (edge_hit !== 1'b0 || r !== 12'hFFF) begin
                errors++;
                $display("FAIL bounce_pos tick %0d: hit=%b rgb=%h want 0 FFF", t, edge_hit, r);
            end
            if (t == 1 || t == 35 || t == 36 || t == 55 || t == 56) begin
                int ex[5] = '{224, 360, 364, 440, 436};
                int ey[5] = '{144, 280, 276, 280, 216};
                int k = (t == 1) ? 0 : (t == 35) ? 1 : (t == 36) ? 2 : (t == 55) ? 3 : 4;
                probe(ex[k], ey[k], 1, 0, r);
                checks++;
                if (r !== 12'hFFF) begin
                    errors++;
                    $display("FAIL bounce_corner tick %0d: (%0d,%0d) rgb=%h want FFF", t, ex[k], ey[k], r);
                end
                probe(ex[k] - 1, ey[k], 1, 0, r);
                checks++;
                if (r !== 12'h137) begin
                    errors++;
                    $display("FAIL bounce_left tick %0d: rgb=%h want 137", t, r);
                end
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_static();
        logic [11:0] r;
        bit eh;
        for (int t = 0; t < 10; t++) begin
            tick((t % 2) ? 2'b11 : 2'b00, eh);
            checks++;
            if (edge_hit !== 1'b0) begin
                errors++;
                $display("FAIL static_hit: got %b want 0", edge_hit);
            end
        end
        probe(436, 216, 1, 0, r);
        checks++;
        if (r !== 12'hFFF) begin
            errors++;
            $display("FAIL static_pos: rgb=%h want FFF", r);
        end
        probe(435, 216, 1, 0, r);
        checks++;
        if (r !== 12'h137) begin
            errors++;
            $display("FAIL static_edge: rgb=%h want 137", r);
        end
    endtask

    task automatic test_recentre();
        logic [11:0] r;
        bit eh;
        tick(2'b10, eh);
        probe(220, 140, 1, 0, r);
        checks++;
        if (r !== 12'hFFF) begin
            errors++;
            $display("FAIL recentre_pos: rgb=%h want FFF", r);
        end
        probe(219, 140, 1, 0, r);
        checks++;
        if (r !== 12'h137) begin
            errors++;
            $display("FAIL recentre_edge: rgb=%h want 137", r);
        end
        // directions were left (x) and up (y) before recentring
        tick(2'b01, eh);
        probe(216, 136, 1, 0, r);
        checks++;
        if (r !== 12'hFFF || mx != 216 || my != 136) begin
            errors++;
            $display("FAIL recentre_dir: rgb=%h want FFF at (216,136)", r);
        end
        probe(220, 340, 1, 0, r);
        checks++;
        if (r !== 12'h137) begin
            errors++;
            $display("FAIL recentre_dir_bottom: rgb=%h want 137", r);
        end
    endtask

    task automatic test_border();
        logic [11:0] r;
        int bx[4] = '{0, 639, 100, 100};
        int by[4] = '{100, 100, 479, 0};
        for (int b = 1; b >= 0; b--) begin
            for (int i = 0; i < 4; i++) begin
                probe(bx[i], by[i], 1, b[0], r);
                checks++;
                if (r !== (b ? 12'hFFF : 12'h137)) begin
                    errors++;
                    $display("FAIL border(%0d,%0d,en=%0d): got %h want %h",
                             bx[i], by[i], b, r, b ? 12'hFFF : 12'h137);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] r, w;
        bit eh;
        int x, y;
        bit d, b;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3)), eh);
                checks++;
                if (edge_hit !== eh) begin
                    errors++;
                    $display("FAIL rand_hit iter %0d: got %b want %b", i, edge_hit, eh);
                end
            end else begin
                case ($urandom_range(0, 3))
                    0: begin x = mx; y = my; end
                    1: begin x = mx + SQ - 1 + $urandom_range(0, 1); y = my + SQ - 1; end
                    2: begin x = mx - 1 + $urandom_range(0, 1); y = my + $urandom_range(0, SQ); end
                    default: begin x = $urandom_range(0, H - 1); y = $urandom_range(0, V - 1); end
                endcase
                if (x < 0) x = 0;
                if (x > H - 1) x = H - 1;
                d = ($urandom_range(0, 7) != 0);
                b = $urandom_range(0, 1);
                w = exp_rgb(x, y, d, b);
                probe(x, y, d, b, r);
                checks++;
                if (r !== w || edge_hit !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_pixel (%0d,%0d,de=%0d,b=%0d): rgb=%h hit=%b want %h 0",
                             x, y, d, b, r, edge_hit, w);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] r;
        bit eh;
        for (int t = 0; t < 7; t++) tick(2'b01, eh);
        sx = 10'(mx); sy = 10'(my); de = 1; hsync = 0; vsync = 0; border_en = 1;
        rst_pix = 1;
        step();
        checks++;
        if ({rgb_now(), vga_hsync, vga_vsync, edge_hit} !== {12'h000, 3'b110}) begin
            errors++;
            $display("FAIL mid_reset: rgb=%h hs=%b vs=%b hit=%b want 000 1 1 0",
                     rgb_now(), vga_hsync, vga_vsync, edge_hit);
        end
        rst_pix = 0; hsync = 1; vsync = 1;
        model_reset();
        probe(220, 140, 1, 0, r);
        checks++;
        if (r !== 12'hFFF) begin
            errors++;
            $display("FAIL mid_reset_pos: rgb=%h want FFF", r);
        end
        probe(219, 140, 1, 0, r);
        checks++;
        if (r !== 12'h137) begin
            errors++;
            $display("FAIL mid_reset_edge: rgb=%h want 137", r);
        end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_sync_delay();
        test_bounce();
        test_static();
        test_recentre();
        test_border();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
